// File: rtl/ltssm_link_trainer.sv
// Link-training sequencer for ltssm_fsm: walks it through the TS word sequence,
// retries failed or stalled attempts and reports link_up / link_fail upward.
module ltssm_link_trainer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 3,
    parameter int RST_CYC     = 4,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          train_req,
    input  logic [3:0]    ltssm_state,
    output logic          ltssm_rst_n,
    output logic          ts_valid,
    output logic [31:0]   ts_data,
    output logic          busy,
    output logic          link_up,
    output logic          link_fail,
    output logic [RW-1:0] retry_cnt
);

    localparam int TMAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [3:0] LT_PACT  = 4'd1;
    localparam logic [3:0] LT_PCFG  = 4'd2;
    localparam logic [3:0] LT_LNW   = 4'd3;
    localparam logic [3:0] LT_CCPL  = 4'd4;
    localparam logic [3:0] LT_CIDLE = 4'd5;
    localparam logic [3:0] LT_L0    = 4'd6;
    localparam logic [3:0] LT_RECOV = 4'd7;

    localparam logic [31:0] TS_DET   = 32'hAAAA_AAAA;
    localparam logic [31:0] TS_PACT  = 32'hBBBB_BBBB;
    localparam logic [31:0] TS_PCFG  = 32'hCCCC_CCCC;
    localparam logic [31:0] TS_CIDLE = 32'hDDDD_DDDD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LRST,
        S_TX_DET,
        S_TX_PACT,
        S_TX_PCFG,
        S_WAIT,
        S_TX_CIDLE,
        S_LINK_UP,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_next;
    state_t        adv_state;
    logic [TW-1:0] timer;
    logic          in_tx;
    logic          exp_met;
    logic          attempt_fail;
    logic          retry_clear;
    logic          retry_bump;
    logic          hold_rst;
    logic          timed;

    // State register plus the flops that depend on the chosen transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            retry_cnt   <= '0;
            ltssm_rst_n <= 1'b0;
        end else begin
            state       <= state_next;
            ltssm_rst_n <= !hold_rst;
            if ((state_next != state) || !timed) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (retry_clear) begin
                retry_cnt <= '0;
            end else if (retry_bump && (retry_cnt != RETRY_MAX)) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        in_tx     = 1'b0;
        exp_met   = 1'b0;
        adv_state = state;
        unique case (state)
            S_TX_DET: begin
                in_tx     = 1'b1;
                exp_met   = (ltssm_state == LT_PACT);
                adv_state = S_TX_PACT;
            end
            S_TX_PACT: begin
                in_tx     = 1'b1;
                exp_met   = (ltssm_state == LT_PCFG);
                adv_state = S_TX_PCFG;
            end
            S_TX_PCFG: begin
                in_tx     = 1'b1;
                exp_met   = (ltssm_state == LT_LNW) || (ltssm_state == LT_CCPL) ||
                            (ltssm_state == LT_CIDLE);
                adv_state = S_WAIT;
            end
            S_WAIT: begin
                in_tx     = 1'b1;
                exp_met   = (ltssm_state == LT_CIDLE);
                adv_state = S_TX_CIDLE;
            end
            S_TX_CIDLE: begin
                in_tx     = 1'b1;
                exp_met   = (ltssm_state == LT_L0);
                adv_state = S_LINK_UP;
            end
            default: ;
        endcase
    end

    // Next state: stop request beats recovery, which beats a match, which beats timeout
    always_comb begin
        state_next   = state;
        attempt_fail = 1'b0;
        if (!train_req) begin
            state_next = S_IDLE;
        end else if (in_tx) begin
            if (ltssm_state == LT_RECOV) begin
                attempt_fail = 1'b1;
            end else if (exp_met) begin
                state_next = adv_state;
            end else if (timer == TMO_LAST) begin
                attempt_fail = 1'b1;
            end
            if (attempt_fail) begin
                state_next = (retry_cnt == RETRY_MAX) ? S_FAIL : S_LRST;
            end
        end else begin
            unique case (state)
                S_IDLE:    state_next = S_LRST;
                S_LRST:    if (timer == RST_LAST) state_next = S_TX_DET;
                S_LINK_UP: if (ltssm_state != LT_L0) state_next = S_LRST;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        timed       = in_tx || (state == S_LRST);
        hold_rst    = (state_next == S_IDLE) || (state_next == S_LRST) ||
                      (state_next == S_FAIL);
        retry_bump  = attempt_fail && (state_next == S_LRST);
        // A fresh training request or a lost link starts a new retry budget
        retry_clear = (state_next == S_LRST) &&
                      ((state == S_IDLE) || (state == S_LINK_UP));
    end

    always_comb begin
        ts_valid  = 1'b0;
        ts_data   = '0;
        busy      = 1'b0;
        link_up   = 1'b0;
        link_fail = 1'b0;
        unique case (state)
            S_LRST: busy = 1'b1;
            S_TX_DET: begin
                busy     = 1'b1;
                ts_valid = 1'b1;
                ts_data  = TS_DET;
            end
            S_TX_PACT: begin
                busy     = 1'b1;
                ts_valid = 1'b1;
                ts_data  = TS_PACT;
            end
            S_TX_PCFG: begin
                busy     = 1'b1;
                ts_valid = 1'b1;
                ts_data  = TS_PCFG;
            end
            S_WAIT: busy = 1'b1;
            S_TX_CIDLE: begin
                busy     = 1'b1;
                ts_valid = 1'b1;
                ts_data  = TS_CIDLE;
            end
            S_LINK_UP: link_up   = 1'b1;
            S_FAIL:    link_fail = 1'b1;
            default: ;
        endcase
    end

endmodule
